// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'h0000_0004;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    fetch_entry_t  mem_r [DEPTH];

    // Storage, pointers and occupancy; reset also zeroes storage so the empty head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited sequential fetches and buffers responses for decode.
// Optional stall counter on out_valid & !out_ready is enabled by defining FETCH_PERF_EN.
module instr_fetch #(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]     stall_cnt,
`endif
    output logic [XLEN-1:0] out_pc
);

    import fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic            inflight_r;
    logic            req_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_data_s;

    // Credit check, response acceptance and decode handshake.
    always_comb begin
        req_s  = 1'b0;
        push_s = 1'b0;
        if (!rst && !redirect_valid && ((32'(count_s) + 32'(inflight_r)) < 32'(FIFO_DEPTH))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        // A response arriving in a redirect or reset cycle belongs to the old stream.
        if (inflight_r && !redirect_valid && !rst) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s             = out_valid & out_ready;
        push_data_s.pc    = inflight_pc_r;
        push_data_s.instr = imem_rdata;
    end

    // PC and in-flight tracking; a redirect drops the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r       <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_r <= 1'b0;
        end else begin
            if (req_s) begin
                pc_r          <= pc_r + XLEN'(PC_STEP);
                inflight_pc_r <= pc_r;
            end
            inflight_r <= req_s;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign imem_req  = req_s;
    assign imem_addr = pc_r;
    assign out_valid = (count_s != '0);
    assign out_instr = head_s.instr;
    assign out_pc    = head_s.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where decode holds back a valid entry; survives redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (out_valid && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference of the fetch stage.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
`ifdef FETCH_PERF_EN
        .stall_cnt      (stall_cnt),
`endif
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: one-cycle synchronous read, always answering.
    always @(posedge clk) imem_rdata <= instr_of(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;
    bit          m_fresh;
    logic [31:0] m_stall;
    logic [31:0] next_acc;
    int          n_vec;
    int          n_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the reference at the edge.
    task automatic cyc(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
        bit exp_valid;
        bit exp_req;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_req   = !r && !rv && ((q.size() + int'(m_infl)) < DEPTH);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
        end else if (m_fresh) begin
            chk("out_pc_reset", out_pc, 32'h0000_0000);
            chk("out_instr_reset", out_instr, 32'h0000_0000);
        end
        if (!r && exp_valid && rdy) begin
            chk("accept_order", out_pc, next_acc);
            chk("accept_word", out_instr, instr_of(next_acc));
        end
`ifdef FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_pc     = RST_PC;
            m_infl   = 1'b0;
            m_fresh  = 1'b1;
            m_stall  = 32'h0000_0000;
            next_acc = RST_PC;
        end else begin
            if (exp_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (exp_valid && rdy) begin
                void'(q.pop_front());
                next_acc = next_acc + 32'd4;
            end
            if (rv) begin
                q.delete();
                m_pc     = {rp[31:2], 2'b00};
                m_infl   = 1'b0;
                next_acc = m_pc;
            end else begin
                if (m_infl) begin
                    q.push_back('{pc: m_ipc, instr: instr_of(m_ipc)});
                    m_fresh = 1'b0;
                end
                if (exp_req) begin
                    m_infl = 1'b1;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bit          r;
        bit          rv;
        bit          rdy;
        logic [31:0] rp;
        n_vec  = 0;
        n_miss = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        out_ready      = 1'b0;
        q.delete();
        m_pc     = RST_PC;
        m_ipc    = 32'h0000_0000;
        m_infl   = 1'b0;
        m_fresh  = 1'b1;
        m_stall  = 32'h0000_0000;
        next_acc = RST_PC;
        repeat (2) @(posedge clk);
        #1;

        // Reset held: no requests, empty output, zeroed data.
        repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // 1: release, decode always ready; first entry at cycle 2, then in PC order.
        repeat (12) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // 2: restart stream at 0, let it fill, stall decode 10 cycles, then release.
        cyc(1'b0, 1'b1, 32'h0000_0000, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // 3: redirect to unaligned 0x103 -> stream from 0x100.
        cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // 4: redirect in the same cycle an entry is accepted.
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_2000, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // 5: address wrap past the top of memory.
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: the last target wins.
        cyc(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_0800, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect together with reset: reset wins.
        cyc(1'b1, 1'b1, 32'h0000_0C00, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // 6: reset mid-stream with one entry buffered and a request in flight.
        cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Full buffer reset variant.
        repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cyc(r, rv, rp, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
